// File: rtl/decoder_ifns_20do_iter.sv
// Iterative IFNS decoder: 29-wire codeword -> 20-bit data word, BITS_PER_CYCLE weighted bits per clock, MSB first.
// Define IFNS_FT_CHECK_EN to add the forbidden-transition flag output ft_err.
module decoder_ifns_20do_iter #(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [28:0] cw,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] v,
  output logic        ovf,
`ifdef IFNS_FT_CHECK_EN
  output logic        ft_err,
`endif
  output logic        busy
);

  localparam int unsigned CW_W   = 29;
  localparam int unsigned ACC_W  = 21;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  // W(k) for wire index k (d_{k+1}): Fibonacci F_{k+1} for k<28, F30 for the top wire
  function automatic logic [ACC_W-1:0] weight(input int unsigned k);
    logic [ACC_W-1:0] a, b, t, w;
    a = ACC_W'(1);
    b = ACC_W'(1);
    w = ACC_W'(832040);
    for (int unsigned i = 0; i < 28; i++) begin
      if (i == k) w = a;
      t = a + b;
      a = b;
      b = t;
    end
    return w;
  endfunction

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   v_q, v_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W-1:0]    chunk_c;
  logic [ACC_W-1:0]    sum_c;
  logic                last_c;

  // Weighted sum of the current chunk, wires idx down to idx-BITS_PER_CYCLE+1
  always_comb begin
    chunk_c = '0;
    for (int unsigned k = 0; k < CW_W; k++) begin
      if ((k <= 32'(idx_q)) && (k + BITS_PER_CYCLE > 32'(idx_q)) && cw_q[k])
        chunk_c = chunk_c + weight(k);
    end
  end

  assign sum_c  = acc_q + chunk_c;
  assign last_c = (32'(idx_q) < BITS_PER_CYCLE);

`ifdef IFNS_FT_CHECK_EN
  logic [CW_W-1:0] prev_cw_q, prev_cw_d;
  logic            ft_err_q, ft_err_d;
  logic [CW_W-1:0] tr_c;

  // Adjacent wires toggling in opposite directions
  assign tr_c = prev_cw_q ^ cw;
  always_comb begin
    prev_cw_d = prev_cw_q;
    ft_err_d  = ft_err_q;
    if (state_q == IDLE && in_valid) begin
      ft_err_d  = |(tr_c[27:0] & tr_c[28:1] & (cw[27:0] ^ cw[28:1]));
      prev_cw_d = cw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cw_q <= '0;
      ft_err_q  <= 1'b0;
    end else begin
      prev_cw_q <= prev_cw_d;
      ft_err_q  <= ft_err_d;
    end
  end

  assign ft_err = ft_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    cw_d        = cw_q;
    out_valid_d = out_valid_q;
    v_d         = v_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cw_d    = cw;
          acc_d   = '0;
          idx_d   = IDX_W'(28);
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum_c;
        if (last_c) begin
          state_d     = DONE;
          v_d         = sum_c[DATA_W-1:0];
          ovf_d       = sum_c[ACC_W-1];
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q - IDX_W'(BITS_PER_CYCLE);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= IDX_W'(28);
      cw_q        <= '0;
      out_valid_q <= 1'b0;
      v_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cw_q        <= cw_d;
      out_valid_q <= out_valid_d;
      v_q         <= v_d;
      ovf_q       <= ovf_d;
    end
  end

  // Handshake flags decode straight from the state flop
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign v         = v_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/decoder_ifns_20do_iter.md
Name: decoder_ifns_20do_iter

Overview:
- Iterative Fibonacci-numeral-system (IFNS) decoder. It is the receive-side inverse of the 20-bit IFNS CAC encoder.
- Accepts one 29-wire codeword (d29..d1) per transaction and returns the 20-bit data word v = sum of d_i * W_i.
- Accumulates BITS_PER_CYCLE weighted bits per clock, so area is traded for latency.
- Sits at the bus receiver, after the wire sampling flops and before the data sink. Uses valid/ready handshakes on both sides.

Parameters:
- BITS_PER_CYCLE, 4, codeword bits summed per ACC cycle. Legal range 1..29. N_ITER = ceil(29/BITS_PER_CYCLE).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  codeword present on cw
- in_ready  output  1  decoder can accept a codeword
- cw  input  29  codeword; cw[28]=d29 ... cw[0]=d1
- out_valid  output  1  v/ovf valid
- out_ready  input  1  sink accepts result
- v  output  20  decoded data word
- ovf  output  1  weighted sum >= 2^20 (illegal codeword)
- busy  output  1  FSM not in IDLE

Behaviour:
- Weights are constants:
  - W_i = F_i for i=1..28, with F1=F2=1, F3=2, ..., F28=317811.
  - W_29 = 832040 (F30).
  - Valid encoder output never sums above 1048575. Maximum possible sum is 1664079, so the accumulator is 21 bits.
- Reset (asynchronous, rst=1): FSM=IDLE, acc=0, idx=28, cw_q=0, out_valid=0, v=0, ovf=0, busy=0. in_ready=1 once rst deasserts.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: cw_q<=cw, acc<=0, idx<=28, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle: acc <= acc + sum of cw_q[k]*W_(k+1) for k = idx down to max(idx-BITS_PER_CYCLE+1, 0). Then idx <= idx-BITS_PER_CYCLE.
  - On the cycle the chunk containing k=0 is added, go to DONE. v<=sum[19:0], ovf<=sum[20], out_valid<=1 are registered on that same edge.
  - MSB-first order is mandatory. The partial sum never wraps because it is 21 bits wide.
- DONE:
  - out_valid=1; v and ovf held stable while out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
- Latency: accept edge to out_valid = N_ITER cycles (8 at default). Throughput is one codeword per N_ITER+2 cycles at best.
- Handshake rules:
  - in_ready is a pure function of state (IDLE only). No combinational path from in_valid or out_ready to in_ready.
  - A codeword is never dropped. The source must hold cw and in_valid until accepted.
  - out_valid never deasserts without out_ready.
- v and ovf keep their last value after the handshake until the next DONE.
- ovf=1 still completes the transaction normally. v is the low 20 bits of the sum (wrapped).
- BITS_PER_CYCLE=29: single ACC cycle. BITS_PER_CYCLE=1: 29 ACC cycles.
- rst asserted in any state, mid-ACC included: immediate return to reset values. The partial result is discarded and no out_valid is produced.

Optional Feature:
- Macro: IFNS_FT_CHECK_EN
- Defined:
  - Adds output ft_err (1 bit) and register prev_cw (29 bits). Both reset to 0.
  - On each accept: ft_err is computed as OR over i=0..27 of (prev_cw[i]^cw[i]) & (prev_cw[i+1]^cw[i+1]) & (cw[i]^cw[i+1]). That is, adjacent wires making opposite transitions, which is a forbidden-transition violation.
  - Then prev_cw<=cw.
  - ft_err is registered and presented with v, valid only while out_valid=1.
  - ft_err does not alter v, ovf or the FSM.
- Undefined: no ft_err port, no prev_cw register, decode behaviour identical.

Test Plan:
- Basic decodes, default parameter: cw=29'h0 -> v=0, ovf=0. cw=29'h1000_0000 (d29 only) -> v=832040. cw=29'h1 -> v=1. cw=29'h2 -> v=1.
- Encoder vector: cw=29'h0000_6030 (d15,d14,d6,d5) -> v=1000, ovf=0, out_valid exactly 8 cycles after the accept edge.
- Overflow: cw=29'h1FFF_FFFF -> v=615503, ovf=1, FSM returns to IDLE after the handshake.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid high on a second codeword -> in_ready=0 throughout, v stable. Release -> second codeword accepted next cycle and decoded correctly.
- Reset mid-ACC: assert rst on the 3rd ACC cycle -> out_valid=0, busy=0 immediately. A fresh codeword after deassert decodes correctly.
- With IFNS_FT_CHECK_EN: send cw=29'h1 then cw=29'h2 -> ft_err=1 on the second result. Send 29'h3 then 29'h0 -> ft_err=0.
